// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the round-robin arbiter.
// Optional hold-limit fairness timer is enabled with ARB_HOLD_LIMIT_EN.
package arb_pkg;

  localparam int MAX_REQ   = 64;
  localparam int MAX_IDX_W = 6;

  localparam logic [MAX_REQ-1:0] IDLE_OH = '0;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_st_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotate-search: first set req bit at or after start,
// wrapping, optionally skipping one excluded index.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [idx_w(NUM_REQ)-1:0] start,
  input  logic                      excl_valid,
  input  logic [idx_w(NUM_REQ)-1:0] excl,
  output logic                      found,
  output logic [NUM_REQ-1:0]        pick
);

  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0] idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(start) + k) % NUM_REQ);
      if (!found && req[idx] &&
          !(excl_valid && idx == excl)) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_arbiter_rr.sv
// N-way round-robin grant FSM with direct handoff and registered grants.
// Define ARB_HOLD_LIMIT_EN to add the HOLD_MAX fairness timeout.
module fsm_arbiter_rr
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      gnt_valid,
  output logic [idx_w(NUM_REQ)-1:0] gnt_id
);

  localparam int IW = idx_w(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  arb_st_e            st;
  logic [NUM_REQ-1:0] owner;
  logic [IW-1:0]      ptr;

  logic [MAX_IDX_W-1:0] own_full;
  logic [MAX_IDX_W-1:0] pick_full;
  logic [IW-1:0]        own_idx;
  logic [IW-1:0]        own_nxt;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        pick_nxt;
  logic [IW-1:0]        start;
  logic                 idle;
  logic                 req_own;
  logic                 found;
  logic                 timeout;
  logic [NUM_REQ-1:0]   pick;

  assign idle     = (st == ST_IDLE);
  assign req_own  = |(req & owner);
  assign own_full = onehot_to_idx(MAX_REQ'(owner));
  assign own_idx  = own_full[IW-1:0];
  assign own_nxt  = (own_idx == LAST) ? '0 : own_idx + 1'b1;
  assign start    = idle ? ptr : own_nxt;

  arb_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (req),
    .start     (start),
    .excl_valid(!idle),
    .excl      (own_idx),
    .found     (found),
    .pick      (pick)
  );

  assign pick_full = onehot_to_idx(MAX_REQ'(pick));
  assign pick_idx  = pick_full[IW-1:0];
  assign pick_nxt  = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  logic [HW-1:0] hold_cnt;

  assign timeout = req_own && (hold_cnt == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= ST_IDLE;
      owner     <= '0;
      ptr       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      gnt       <= owner;
      gnt_valid <= |owner;
      gnt_id    <= own_idx;
      unique case (st)
        ST_IDLE: begin
          if (found) begin
            st    <= ST_GRANT;
            owner <= pick;
            ptr   <= pick_nxt;
          end
        end
        ST_GRANT: begin
          if (req_own && !timeout) begin
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end else if (found) begin
            owner <= pick;
            ptr   <= pick_nxt;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
          end else if (timeout) begin
            // lone requester: keep it, restart its window
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
          end else begin
            st    <= ST_IDLE;
            owner <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
          end
        end
        default: begin
          st    <= ST_IDLE;
          owner <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fsm_arbiter_rr.md
# fsm_arbiter_rr

Parametrised N-way round-robin arbiter FSM for shared-resource access in the asic-world integration set. It generalises the two-requester grant FSM to NUM_REQ requesters. Grants hand off directly between requesters with no IDLE bubble. An optional hold-limit timer enforces fairness under continuous contention. Grants are registered, one-hot, and also provided as an encoded id.

## Interface
- NUM_REQ, default 4: number of requesters; must be ≥ 2.
- HOLD_MAX, default 8: maximum consecutive cycles one owner keeps the grant while others request; must be ≥ 1; used only with the hold-limit macro.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request vector; bit i is requester i; level-sensitive.
- gnt  output  NUM_REQ  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  registered; equals OR-reduction of gnt.
- gnt_id  output  $clog2(NUM_REQ)  registered index of the granted requester; 0 when idle.

## Operation
- Internal state:
  - owner: one-hot NUM_REQ bits; all zero is IDLE.
  - ptr: round-robin start index, $clog2(NUM_REQ) bits.
  - hold_cnt: $clog2(HOLD_MAX+1) bits; present only with the macro.
- Pick(start, excl): first set bit of req, searching from index start upward with wrap mod NUM_REQ, skipping index excl if given. Returns none if no eligible bit is set.
- IDLE:
  - If any req bit is set, owner ← Pick(ptr).
  - Otherwise stay in IDLE.
- GRANT(i), req[i]=1, no timeout: stay in GRANT(i).
- GRANT(i), req[i]=0:
  - owner ← Pick(i+1, excl i), a direct handoff.
  - If Pick returns none, go to IDLE.
- GRANT(i), timeout (macro only): timeout means req[i]=1 and hold_cnt == HOLD_MAX−1.
  - owner ← Pick(i+1, excl i).
  - If Pick returns none, stay in GRANT(i) and clear hold_cnt.
- Whenever owner becomes index j from a different value, ptr ← (j+1) mod NUM_REQ. Wrap from NUM_REQ−1 goes to 0.
- hold_cnt:
  - Cleared on every owner change and in IDLE.
  - Increments each cycle the owner stays the same and is non-zero.
  - Never exceeds HOLD_MAX−1.
- Outputs:
  - gnt ← owner.
  - gnt_valid ← |owner.
  - gnt_id ← encode(owner).
- Simultaneous requests: the lowest index at or after ptr (cyclically) wins.
- Reset values:
  - owner=0, ptr=0, hold_cnt=0.
  - gnt=0, gnt_valid=0, gnt_id=0.
- Reset overrides all other transitions, including mid-grant.

## Timing
- req sampled at edge t → owner updated at edge t → gnt, gnt_valid and gnt_id updated at edge t+1. Request-to-grant latency is 2 edges.
- req[i] sampled low at edge t → gnt[i] deasserts after edge t+1. The next owner's gnt bit asserts on that same edge, so at most one gnt bit is high in any cycle.
- A reset asserted at edge t clears gnt after edge t. The first grant is possible after edge t+2 following deassertion.
- With the macro, a continuously requesting owner holds owner state for exactly HOLD_MAX cycles when another request is pending.

## Configuration
- ARB_HOLD_LIMIT_EN defined:
  - hold_cnt and the timeout transition are compiled in.
  - Fair rotation under sustained contention.
- ARB_HOLD_LIMIT_EN undefined:
  - No counter.
  - An owner keeps the grant for as long as its req stays high.
  - HOLD_MAX is ignored.

## Structure
- Shared package arb_pkg holds:
  - the IDX_W = $clog2(NUM_REQ) width helper;
  - the onehot_to_idx function;
  - the IDLE (all-zero owner) constant.
- Sub-module arb_rr_pick: purely combinational rotate-search. Inputs are req, start and excl_valid/excl; outputs are a found flag and a one-hot pick. It is instantiated once.
- Top level holds the owner, ptr and hold_cnt registers and the output registers.

## Test plan
All scenarios use NUM_REQ=4 and HOLD_MAX=4.
- Reset with req=4'b1111 held: gnt=0, gnt_valid=0 and gnt_id=0 during reset. After reset drops, gnt=4'b0001 and gnt_id=0 two edges later.
- Single request, req=4'b0100: gnt=4'b0100 and gnt_id=2 after 2 edges. Clearing req gives gnt=0 and gnt_valid=0 after 2 edges.
- Handoff with owner=1 and req=4'b1010: dropping req[1] gives gnt=4'b1000 on the next grant update, with no all-zero cycle in between.
- Rotation with macro, req=4'b1111 held: gnt cycles 0001→0010→0100→1000→0001, each held exactly 4 cycles.
- Without macro, req=4'b1111 held for 100 cycles: gnt stays 0001. Dropping req[0] gives gnt=0010.
- Reset mid-grant with owner=2 and hold_cnt=3: gnt=0 after the reset edge and ptr=0. Then req=4'b1100 grants index 2.
